perf_dump_unit: RTL and testbench

Collection end of the performance-event path: PERF-style event sources drive per-cycle increment fields, and this block accumulates them into a counter bank. It provides a registered random-access read port and a triggered snapshot-and-stream dump over a valid/ready channel. The CSR unit or the difftest host reads the counters through it. Sits at core top level beside the CSR file.

---
 rtl/perf_dump_unit_pkg.sv | 26 ++
 rtl/perf_dump_unit_if.sv | 30 +++
 rtl/perf_dump_unit_counter.sv | 66 ++++++
 rtl/perf_dump_unit.sv | 139 +++++++++++++
 tb/tb_perf_dump_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/perf_dump_unit_pkg.sv
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and default sizes for the performance counter
//               bank and its snapshot dump path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package perf_pkg;

    localparam int PERF_EVENT_NUM = 16;
    localparam int PERF_CNT_WIDTH = 32;
    localparam int PERF_INC_WIDTH = 3;

    typedef logic [PERF_CNT_WIDTH-1:0] perf_cnt_t;
    typedef logic [PERF_INC_WIDTH-1:0] perf_inc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNAP   = 2'd1,
        STREAM = 2'd2
    } perf_dump_state_t;

endpackage : perf_pkg

`default_nettype wire

// File: rtl/perf_dump_unit_if.sv
// ============================================================================
// Module      : perf_dump_unit_if
// Description : Valid/ready dump stream carrying one counter snapshot per beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface perf_dump_unit_if #(
    parameter int IDX_WIDTH = 4,
    parameter int CNT_WIDTH = 32
);
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_WIDTH-1:0] out_idx;
    logic [CNT_WIDTH-1:0] out_data;
    logic                 out_ovf;
    logic                 out_last;

    modport master (
        output out_valid, out_idx, out_data, out_ovf, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_idx, out_data, out_ovf, out_last,
        output out_ready
    );
endinterface : perf_dump_unit_if

`default_nettype wire

// File: rtl/perf_dump_unit_counter.sv
// ============================================================================
// Module      : perf_counter
// Description : One event counter with sticky overflow flag; clear beats the
//               increment. Macro PERF_SAT_EN selects saturating counting,
//               otherwise the counter wraps and the flag records carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [INC_WIDTH-1:0] inc,
    input  wire logic                 clear,
    output logic      [CNT_WIDTH-1:0] cnt,
    output logic                      ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH:0]   w_sum;

    // Next counter value: clear wins, otherwise add with wrap or saturate
    always_comb begin
        w_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
`ifdef PERF_SAT_EN
            if (w_sum[CNT_WIDTH]) begin
                cnt_d = '1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = w_sum[CNT_WIDTH-1:0];
                ovf_d = ovf_q | (&w_sum[CNT_WIDTH-1:0]);
            end
`else
            cnt_d = w_sum[CNT_WIDTH-1:0];
            ovf_d = ovf_q | w_sum[CNT_WIDTH];
`endif
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule : perf_counter

`default_nettype wire

// File: rtl/perf_dump_unit.sv
// ============================================================================
// Module      : perf_dump_unit
// Description : Performance counter bank with a registered random-read port
//               and a snapshot-then-stream dump over a valid/ready channel.
//               Build option PERF_SAT_EN makes counters saturate (see
//               perf_counter); the port list is the same either way.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_dump_unit
    import perf_pkg::*;
#(
    parameter int EVENT_NUM = PERF_EVENT_NUM,
    parameter int CNT_WIDTH = PERF_CNT_WIDTH,
    parameter int INC_WIDTH = PERF_INC_WIDTH,
    parameter int IDX_WIDTH = $clog2(EVENT_NUM)
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic [EVENT_NUM*INC_WIDTH-1:0] ev_inc,
    input  wire logic                           clear,
    input  wire logic [IDX_WIDTH-1:0]           rd_idx,
    output logic      [CNT_WIDTH-1:0]           rd_data,
    input  wire logic                           dump_req,
    output logic                                dump_busy,
    perf_dump_unit_if.master                    out_if
);

    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(EVENT_NUM - 1);

    logic [CNT_WIDTH-1:0] w_cnt [EVENT_NUM];
    logic [EVENT_NUM-1:0] w_ovf;

    perf_dump_state_t     state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] snap_q [EVENT_NUM];
    logic [CNT_WIDTH-1:0] snap_d [EVENT_NUM];
    logic [EVENT_NUM-1:0] snap_ovf_q, snap_ovf_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

    generate
        for (genvar i = 0; i < EVENT_NUM; i++) begin : g_cnt
            perf_counter #(
                .CNT_WIDTH (CNT_WIDTH),
                .INC_WIDTH (INC_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (ev_inc[i*INC_WIDTH +: INC_WIDTH]),
                .clear (clear),
                .cnt   (w_cnt[i]),
                .ovf   (w_ovf[i])
            );
        end
    endgenerate

    // Read port samples the live (pre-update) counter; out-of-range reads 0
    always_comb begin
        rd_data_d = '0;
        if (rd_idx <= C_LAST_IDX) begin
            rd_data_d = w_cnt[rd_idx];
        end
    end

    // Dump sequencing: capture the whole bank once, then walk it beat by beat
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_d     = w_cnt;
                snap_ovf_d = w_ovf;
                ptr_d      = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                if (out_if.out_ready) begin
                    if (ptr_q == C_LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stream outputs are a pure function of state, so a stall holds them
    always_comb begin
        out_if.out_valid = 1'b0;
        out_if.out_idx   = '0;
        out_if.out_data  = '0;
        out_if.out_ovf   = 1'b0;
        out_if.out_last  = 1'b0;
        dump_busy        = (state_q != IDLE);
        if (state_q == STREAM) begin
            out_if.out_valid = 1'b1;
            out_if.out_idx   = ptr_q;
            out_if.out_data  = snap_q[ptr_q];
            out_if.out_ovf   = snap_ovf_q[ptr_q];
            out_if.out_last  = (ptr_q == C_LAST_IDX);
        end
    end

    // State, pointer, snapshot and read-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            snap_ovf_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < EVENT_NUM; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            snap_ovf_q <= snap_ovf_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < EVENT_NUM; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule : perf_dump_unit

`default_nettype wire

// File: tb/tb_perf_dump_unit.sv
// ============================================================================
// Module      : tb_perf_dump_unit
// Description : Directed self-checking bench for perf_dump_unit. A second,
//               narrow instance (4-bit counters, 2 events) exercises the
//               wrap / saturation boundary without needing ~2^32 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_perf_dump_unit;

    localparam int EN = 16;
    localparam int CW = 32;
    localparam int IW = 3;
    localparam int XW = 4;
    localparam int SN = 2;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [EN*IW-1:0]  ev_inc;
    logic              clear;
    logic [XW-1:0]     rd_idx;
    logic [CW-1:0]     rd_data;
    logic              dump_req;
    logic              dump_busy;
    perf_dump_unit_if #(.IDX_WIDTH(XW), .CNT_WIDTH(CW)) m_if ();

    logic [SN*IW-1:0]  s_ev_inc;
    logic              s_clear;
    logic              s_rd_idx;
    logic [SW-1:0]     s_rd_data;
    logic              s_dump_req;
    logic              s_dump_busy;
    perf_dump_unit_if #(.IDX_WIDTH(1), .CNT_WIDTH(SW)) s_if ();

    perf_dump_unit u_dut (
        .clk       (clk),
        .rst       (rst),
        .ev_inc    (ev_inc),
        .clear     (clear),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .dump_req  (dump_req),
        .dump_busy (dump_busy),
        .out_if    (m_if)
    );

    perf_dump_unit #(
        .EVENT_NUM (SN),
        .CNT_WIDTH (SW),
        .INC_WIDTH (IW)
    ) u_dut_small (
        .clk       (clk),
        .rst       (rst),
        .ev_inc    (s_ev_inc),
        .clear     (s_clear),
        .rd_idx    (s_rd_idx),
        .rd_data   (s_rd_data),
        .dump_req  (s_dump_req),
        .dump_busy (s_dump_busy),
        .out_if    (s_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         rem [EN];
        int         ptr;
        int         cyc;
        int         beats;
        logic       rdy;
        logic [3:0] pat;
        logic [SW-1:0] s_exp;

        rst = 1'b0; ev_inc = '0; clear = 1'b0; rd_idx = '0; dump_req = 1'b0;
        m_if.out_ready = 1'b0;
        s_ev_inc = '0; s_clear = 1'b0; s_rd_idx = 1'b0; s_dump_req = 1'b0;
        s_if.out_ready = 1'b0;
        pat = 4'b1001;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst rd_data", rd_data, 0);
        check("rst busy", dump_busy, 0);
        check("rst valid", m_if.out_valid, 0);
        check("rst data", m_if.out_data, 0);
        check("rst last", m_if.out_last, 0);
        rst = 1'b1;

        // Test 1: field 3 += 2 for 10 cycles
        rd_idx = 4'd3;
        ev_inc[3*IW +: IW] = 3'd2;
        repeat (10) @(negedge clk);
        ev_inc = '0;
        @(negedge clk);
        check("t1 cnt3", rd_data, 20);
        for (int k = 0; k < EN; k++) begin
            rd_idx = XW'(k);
            @(negedge clk);
            check($sformatf("t1 sweep %0d", k), rd_data, (k == 3) ? 20 : 0);
        end

        // Test 2 (narrow instance): 13 then +5 crosses the 4-bit limit
        s_ev_inc[0 +: IW] = 3'd7;
        @(negedge clk);
        s_ev_inc[0 +: IW] = 3'd6;
        @(negedge clk);
        s_ev_inc = '0;
        @(negedge clk);
        check("t2 preload", s_rd_data, 13);
        s_ev_inc[0 +: IW] = 3'd5;
        @(negedge clk);
        s_ev_inc = '0;
        @(negedge clk);
`ifdef PERF_SAT_EN
        s_exp = 4'hF;
`else
        s_exp = 4'h2;
`endif
        check("t2 cnt0", s_rd_data, s_exp);
        s_if.out_ready = 1'b1;
        s_dump_req = 1'b1;
        @(negedge clk);
        s_dump_req = 1'b0;
        @(negedge clk);
        check("t2 b0 valid", s_if.out_valid, 1);
        check("t2 b0 data", s_if.out_data, s_exp);
        check("t2 b0 ovf", s_if.out_ovf, 1);
        check("t2 b0 last", s_if.out_last, 0);
        @(negedge clk);
        check("t2 b1 idx", s_if.out_idx, 1);
        check("t2 b1 data", s_if.out_data, 0);
        check("t2 b1 ovf", s_if.out_ovf, 0);
        check("t2 b1 last", s_if.out_last, 1);
        @(negedge clk);
        check("t2 end valid", s_if.out_valid, 0);

        // Test 3: clear and increment in the same cycle
        rd_idx = 4'd1;
        ev_inc[1*IW +: IW] = 3'd1;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ev_inc = '0;
        check("t3 pre-clear", rd_data, 3);
        @(negedge clk);
        check("t3 cnt1", rd_data, 0);
        rd_idx = 4'd3;
        @(negedge clk);
        check("t3 cnt3", rd_data, 0);

        // Test 4: load cnt[i] = i*100, dump with ready held high
        for (int i = 0; i < EN; i++) rem[i] = i * 100;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < EN; i++) begin
                ev_inc[i*IW +: IW] = IW'((rem[i] > 7) ? 7 : rem[i]);
                rem[i] = (rem[i] > 7) ? rem[i] - 7 : 0;
            end
            @(negedge clk);
        end
        ev_inc = '0;
        rd_idx = 4'd15;
        @(negedge clk);
        check("t4 cnt15", rd_data, 1500);
        m_if.out_ready = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        check("t4 snap busy", dump_busy, 1);
        check("t4 snap valid", m_if.out_valid, 0);
        @(negedge clk);
        for (int i = 0; i < EN; i++) begin
            check($sformatf("t4 valid %0d", i), m_if.out_valid, 1);
            check($sformatf("t4 idx %0d", i), m_if.out_idx, i);
            check($sformatf("t4 data %0d", i), m_if.out_data, i * 100);
            check($sformatf("t4 ovf %0d", i), m_if.out_ovf, 0);
            check($sformatf("t4 last %0d", i), m_if.out_last, (i == EN - 1) ? 1 : 0);
            @(negedge clk);
        end
        check("t4 end busy", dump_busy, 0);
        check("t4 end valid", m_if.out_valid, 0);

        // Test 5: stalls (ready 1,0,0,1) while field 2 keeps counting
        m_if.out_ready = 1'b0;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        ev_inc[2*IW +: IW] = 3'd1;
        @(negedge clk);
        ptr = 0;
        cyc = 0;
        while (ptr < EN && cyc < 100) begin
            check($sformatf("t5 valid c%0d", cyc), m_if.out_valid, 1);
            check($sformatf("t5 idx c%0d", cyc), m_if.out_idx, ptr);
            check($sformatf("t5 data c%0d", cyc), m_if.out_data, ptr * 100);
            rdy = pat[cyc % 4];
            m_if.out_ready = rdy;
            @(negedge clk);
            if (rdy) ptr++;
            cyc++;
        end
        check("t5 beats", ptr, EN);
        check("t5 end valid", m_if.out_valid, 0);
        ev_inc = '0;
        rd_idx = 4'd2;
        @(negedge clk);
        check("t5 live cnt2", rd_data, 201 + cyc);

        // Test 6a: second dump_req mid-stream is dropped
        m_if.out_ready = 1'b1;
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        @(negedge clk);
        beats = 0;
        cyc = 0;
        while (m_if.out_valid && cyc < 60) begin
            dump_req = (beats == 3);
            beats++;
            @(negedge clk);
            cyc++;
        end
        dump_req = 1'b0;
        check("t6 beats", beats, EN);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t6 idle busy %0d", k), dump_busy, 0);
            @(negedge clk);
        end

        // Test 6b: reset at beat 5 aborts the stream
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        repeat (6) @(negedge clk);
        check("t6 beat5 idx", m_if.out_idx, 5);
        rst = 1'b0;
        #1;
        check("t6 rst valid", m_if.out_valid, 0);
        check("t6 rst busy", dump_busy, 0);
        check("t6 rst data", m_if.out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        rd_idx = 4'd5;
        @(negedge clk);
        check("t6 post cnt5", rd_data, 0);
        check("t6 post valid", m_if.out_valid, 0);
        check("t6 post busy", dump_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_perf_dump_unit

`default_nettype wire
